ps2_kbd_rx: RTL and testbench

- Keyboard front end that sits directly upstream of the memory-mapped I/O decoder.
- Samples the external PS/2 clock/data pins and deserialises 11-bit frames.
- Checks each frame and buffers good scan codes in a small show-ahead FIFO.
- Presents the FIFO head to the MMIO read path as kb_data/kb_ready; the MMIO read strobe sig_rd_kb pops one entry.

---
 rtl/ps2_kbd_rx.sv | 163 ++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the pins, deserialises 11-bit frames and queues good scan codes.
// Optional build macro KB_BREAK_FILTER_EN drops each 0xF0 break prefix together with the byte that follows it.
module ps2_kbd_rx #(
    parameter int KB_WIDTH    = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    input  logic                sig_rd_kb,
    output logic [KB_WIDTH-1:0] kb_data,
    output logic                kb_ready,
    output logic                kb_overflow,
    output logic                kb_frame_err
);
    localparam int FRAME_BITS = KB_WIDTH + 2;
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t                state, state_next;
    logic [CW-1:0]         bit_cnt, bit_cnt_next;
    logic [TW-1:0]         tmo_cnt, tmo_cnt_next;
    logic [FRAME_BITS-1:0] shift_reg;
    logic                  ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
    logic                  ps2_data_p0, ps2_data_p1;
    logic                  fall, err_set, push_req;
    logic [AW:0]           wr_ptr, rd_ptr;
    logic [KB_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic                  empty, full, push, pop;
`ifdef KB_BREAK_FILTER_EN
    logic                  discard, discard_next;
`endif

    // Shift register holds data LSB-first, then parity, then stop in the MSB.
    function automatic logic frame_good(input logic [FRAME_BITS-1:0] f);
        return f[FRAME_BITS-1] && ((^f[KB_WIDTH-1:0] ^ f[KB_WIDTH]) == 1'b1);
    endfunction

    // Stage p0/p1: metastability synchroniser; p2: previous clock level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2_clk_p0  <= 1'b1;
            ps2_clk_p1  <= 1'b1;
            ps2_clk_p2  <= 1'b1;
            ps2_data_p0 <= 1'b1;
            ps2_data_p1 <= 1'b1;
        end else begin
            ps2_clk_p0  <= ps2_clk;
            ps2_clk_p1  <= ps2_clk_p0;
            ps2_clk_p2  <= ps2_clk_p1;
            ps2_data_p0 <= ps2_data;
            ps2_data_p1 <= ps2_data_p0;
        end
    end

    assign fall = ps2_clk_p2 & ~ps2_clk_p1;

    always_ff @(posedge clk) begin
        if (state == RECV && fall)
            shift_reg <= {ps2_data_p1, shift_reg[FRAME_BITS-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            tmo_cnt      <= '0;
            kb_frame_err <= 1'b0;
`ifdef KB_BREAK_FILTER_EN
            discard      <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            bit_cnt      <= bit_cnt_next;
            tmo_cnt      <= tmo_cnt_next;
            kb_frame_err <= err_set;
`ifdef KB_BREAK_FILTER_EN
            discard      <= discard_next;
`endif
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        tmo_cnt_next = tmo_cnt;
        err_set      = 1'b0;
        push_req     = 1'b0;
`ifdef KB_BREAK_FILTER_EN
        discard_next = discard;
`endif
        case (state)
            IDLE: begin
                bit_cnt_next = '0;
                tmo_cnt_next = '0;
                if (fall) begin
                    if (!ps2_data_p1) state_next = RECV;
                    else              err_set    = 1'b1;
                end
            end
            RECV: begin
                if (fall) begin
                    bit_cnt_next = bit_cnt + 1'b1;
                    tmo_cnt_next = '0;
                    if (bit_cnt == CW'(FRAME_BITS - 1)) state_next = CHECK;
                end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt + 1'b1;
                end
            end
            CHECK: begin
                state_next = IDLE;
                if (frame_good(shift_reg)) begin
`ifdef KB_BREAK_FILTER_EN
                    if (discard)
                        discard_next = 1'b0;
                    else if (shift_reg[KB_WIDTH-1:0] == KB_WIDTH'(8'hF0))
                        discard_next = 1'b1;
                    else
                        push_req = 1'b1;
`else
                    push_req = 1'b1;
`endif
                end else begin
                    err_set = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = sig_rd_kb && !empty;
    assign push  = push_req && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            kb_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push_req && full && !pop) kb_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= shift_reg[KB_WIDTH-1:0];
    end

    assign kb_ready = !empty;
    assign kb_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: table vectors, hand-written corner sequences and random frames vs a queue model.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;
    localparam int KW    = 8;
    localparam int DEPTH = 8;
    localparam int TO    = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ps2_clk = 1'b1;
    logic          ps2_data = 1'b1;
    logic          sig_rd_kb = 1'b0;
    logic [KW-1:0] kb_data;
    logic          kb_ready, kb_overflow, kb_frame_err;

    ps2_kbd_rx #(.KB_WIDTH(KW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .sig_rd_kb(sig_rd_kb),
        .kb_data(kb_data), .kb_ready(kb_ready), .kb_overflow(kb_overflow), .kb_frame_err(kb_frame_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int err_seen = 0;
    int err_exp = 0;
    byte unsigned q[$];
    bit m_ovf = 0;
    bit m_disc = 0;

    always @(negedge clk) if (kb_frame_err) err_seen <= err_seen + 1;

    typedef struct {
        byte unsigned d;
        bit bp;
        bit bs;
        bit exp_push;
        bit exp_err;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input byte unsigned d, input bit bp, input bit bs);
        logic par;
        par = ~(^d) ^ bp;
        return {~bs, par, d, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b, input int half);
        @(negedge clk) ps2_data = b;
        repeat (half) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (half) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_raw(input logic [10:0] f, input int n, input int half);
        for (int i = 0; i < n; i++) ps2_bit(f[i], half);
    endtask

    task automatic model_push(input byte unsigned d);
        if (q.size() < DEPTH) q.push_back(d);
        else m_ovf = 1'b1;
    endtask

    task automatic model_frame(input byte unsigned d, input bit bp, input bit bs);
        if (bp || bs) err_exp++;
        else begin
`ifdef KB_BREAK_FILTER_EN
            if (m_disc) m_disc = 1'b0;
            else if (d == 8'hF0) m_disc = 1'b1;
            else model_push(d);
`else
            model_push(d);
`endif
        end
    endtask

    task automatic send_m(input byte unsigned d, input bit bp, input bit bs, input int half);
        send_raw(mk_frame(d, bp, bs), 11, half);
        @(negedge clk) ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        model_frame(d, bp, bs);
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        chk({tag, "/ready"}, kb_ready, (q.size() != 0));
        chk({tag, "/data"}, kb_data, (q.size() != 0) ? q[0] : 8'h00);
        chk({tag, "/ovf"}, kb_overflow, m_ovf);
        chk({tag, "/err"}, err_seen, err_exp);
    endtask

    task automatic pop_m(input string tag);
        @(negedge clk);
        if (q.size() == 0) begin
            chk({tag, "/empty"}, kb_ready, 0);
            sig_rd_kb = 1'b1;
            @(negedge clk) sig_rd_kb = 1'b0;
        end else begin
            chk({tag, "/pop"}, kb_data, q[0]);
            sig_rd_kb = 1'b1;
            @(negedge clk) sig_rd_kb = 1'b0;
            void'(q.pop_front());
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        m_disc = 1'b0;
    endtask

    initial begin
        logic [10:0] f;
        byte unsigned fexp[$];
        byte unsigned exp_full[$];

        tbl[0] = '{8'h1C, 0, 0, 1, 0};
        tbl[1] = '{8'h1C, 1, 0, 0, 1};
        tbl[2] = '{8'h1C, 0, 1, 0, 1};
        tbl[3] = '{8'h00, 0, 0, 1, 0};
        tbl[4] = '{8'hFF, 0, 0, 1, 0};
        tbl[5] = '{8'h80, 1, 0, 0, 1};
        tbl[6] = '{8'h7E, 0, 1, 0, 1};
        tbl[7] = '{8'hA5, 0, 0, 1, 0};

        repeat (3) @(negedge clk);
        chk("rst/data", kb_data, 0);
        chk("rst/ready", kb_ready, 0);
        chk("rst/ovf", kb_overflow, 0);
        chk("rst/err", kb_frame_err, 0);
        rst = 1'b0;
        check_state("idle");

        // First frame with exact latency: visible 2 cycles after the edge is seen behind the 2-flop sync.
        f = mk_frame(8'h1C, 0, 0);
        send_raw(f, 10, 4);
        @(negedge clk) ps2_data = f[10];
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("lat/early", kb_ready, 0);
        @(posedge clk);
        #1 chk("lat/ready", kb_ready, 1);
        chk("lat/data", kb_data, 8'h1C);
        @(negedge clk) begin ps2_clk = 1'b1; ps2_data = 1'b1; end
        q.push_back(8'h1C);
        pop_m("lat");
        @(negedge clk);
        chk("lat/after_pop_ready", kb_ready, 0);
        chk("lat/after_pop_data", kb_data, 0);

        for (int i = 0; i < 8; i++) begin
            int e0;
            e0 = err_seen;
            send_m(tbl[i].d, tbl[i].bp, tbl[i].bs, 4);
            @(negedge clk);
            chk($sformatf("tbl%0d/ready", i), kb_ready, tbl[i].exp_push);
            if (tbl[i].exp_push) chk($sformatf("tbl%0d/data", i), kb_data, tbl[i].d);
            chk($sformatf("tbl%0d/err", i), err_seen - e0, tbl[i].exp_err);
            if (q.size() != 0) pop_m($sformatf("tbl%0d", i));
        end
        check_state("tbl_end");

        // Start bit of 1 is rejected on its own edge.
        ps2_bit(1'b1, 4);
        @(negedge clk) ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        err_exp++;
        check_state("startbit");

        // Partial frame abandoned after TIMEOUT_CYC idle cycles.
        send_raw(mk_frame(8'h55, 0, 0), 4, 4);
        @(negedge clk) ps2_data = 1'b1;
        repeat (TO - 40) @(negedge clk);
        chk("tmo/early", err_seen, err_exp);
        repeat (80) @(negedge clk);
        err_exp++;
        check_state("tmo");
        send_m(8'h2A, 0, 0, 4);
        check_state("tmo/next");
        chk("tmo/2A", kb_data, 8'h2A);
        pop_m("tmo");

        // Nine codes into an eight-deep FIFO.
        for (int i = 1; i <= 9; i++) send_m(8'(i), 0, 0, 3);
        check_state("ovf");
        chk("ovf/flag", kb_overflow, 1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk) chk($sformatf("ovf/order%0d", i), kb_data, i);
            pop_m("ovf");
        end
        check_state("ovf/drained");
        chk("ovf/sticky", kb_overflow, 1);

        // Reset in the middle of a frame with a code queued.
        send_m(8'h66, 0, 0, 4);
        send_raw(mk_frame(8'h5A, 0, 0), 5, 4);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("midrst/data", kb_data, 0);
        chk("midrst/ready", kb_ready, 0);
        chk("midrst/ovf", kb_overflow, 0);
        chk("midrst/err", kb_frame_err, 0);
        @(negedge clk) begin rst = 1'b0; ps2_data = 1'b1; end
        q.delete();
        m_ovf = 1'b0;
        m_disc = 1'b0;
        repeat (20) @(negedge clk);
        check_state("midrst/after");

        // Full FIFO: pop coincides with the CHECK cycle of 0x33.
        do_reset();
        for (int i = 0; i < 8; i++) send_m(8'h10 + 8'(i), 0, 0, 3);
        check_state("full");
        f = mk_frame(8'h33, 0, 0);
        send_raw(f, 10, 4);
        @(negedge clk) ps2_data = f[10];
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) sig_rd_kb = 1'b1;
        @(negedge clk) sig_rd_kb = 1'b0;
        @(negedge clk) begin ps2_clk = 1'b1; ps2_data = 1'b1; end
        void'(q.pop_front());
        q.push_back(8'h33);
        check_state("fullpop");
        chk("fullpop/ovf", kb_overflow, 0);
        exp_full = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h33};
        foreach (exp_full[i]) begin
            @(negedge clk) chk($sformatf("fullpop/e%0d", i), kb_data, exp_full[i]);
            pop_m("fullpop");
        end
        check_state("fullpop/drained");

        // Held read strobe pops one entry per cycle; pops while empty are ignored.
        send_m(8'h41, 0, 0, 3);
        send_m(8'h42, 0, 0, 3);
        send_m(8'h43, 0, 0, 3);
        @(negedge clk) sig_rd_kb = 1'b1;
        repeat (2) @(negedge clk);
        sig_rd_kb = 1'b0;
        void'(q.pop_front());
        void'(q.pop_front());
        check_state("hold");
        chk("hold/43", kb_data, 8'h43);
        pop_m("hold");
        @(negedge clk) sig_rd_kb = 1'b1;
        repeat (3) @(negedge clk);
        sig_rd_kb = 1'b0;
        send_m(8'h55, 0, 0, 4);
        check_state("emptypop");
        chk("emptypop/55", kb_data, 8'h55);
        pop_m("emptypop");

        // Break-code handling.
        send_m(8'hF0, 0, 0, 4);
        send_m(8'h1C, 0, 0, 4);
        send_m(8'h32, 0, 0, 4);
`ifdef KB_BREAK_FILTER_EN
        fexp = '{8'h32};
`else
        fexp = '{8'hF0, 8'h1C, 8'h32};
`endif
        check_state("brk");
        foreach (fexp[i]) begin
            @(negedge clk) chk($sformatf("brk/e%0d", i), kb_data, fexp[i]);
            pop_m("brk");
        end
        check_state("brk/drained");

        // Random frames, corruptions and reads against the model.
        for (int n = 0; n < 40; n++) begin
            byte unsigned d;
            int r;
            d = 8'($urandom);
            r = $urandom_range(0, 5);
            send_m(d, (r == 0), (r == 1), $urandom_range(3, 7));
            check_state($sformatf("rnd%0d", n));
            if ($urandom_range(0, 2) == 0) begin
                int k;
                k = $urandom_range(0, 3);
                for (int j = 0; j < k; j++) pop_m($sformatf("rnd%0d", n));
            end
        end
        while (q.size() != 0) pop_m("rnd_drain");
        check_state("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
